// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU (p0) has priority, with a hold limit that guarantees p1 progress.
// Optional out-of-range checking is enabled by defining DMEM_ARB_RANGE_EN.
module dmem_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_be,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_be,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic [31:0] m_daddr,
  output logic [31:0] m_dwdata,
  output logic [3:0]  m_dwe,
  input  logic [31:0] m_drdata,
  output logic        err
);

  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_P0   = 2'd1;
  localparam logic [1:0] OWNER_P1   = 2'd2;
  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

  logic [3:0]  hold_cnt_q, hold_cnt_d;
  logic [1:0]  last_owner_q, last_owner_d;
  logic        p0_rvalid_q, p1_rvalid_q;
  logic [31:0] p0_rdata_q, p1_rdata_q;
  logic        force_p1;
  logic        gnt0, gnt1;
  logic        oor0, oor1;
  logic        sel_oor;
  logic        rd0, rd1;

`ifdef DMEM_ARB_RANGE_EN
  // Only the low 16 KiB of the address space is backed by memory.
  assign oor0 = |p0_addr[31:14];
  assign oor1 = |p1_addr[31:14];
`else
  assign oor0 = 1'b0;
  assign oor1 = 1'b0;
`endif

  // p1 has waited through MAX_HOLD consecutive p0 grants: it wins this cycle.
  assign force_p1 = p1_req && (hold_cnt_q == HOLD_LIMIT);

  always_comb begin
    gnt0 = rst_n && p0_req && !force_p1;
    gnt1 = rst_n && p1_req && !gnt0;
  end

  assign p0_gnt = gnt0;
  assign p1_gnt = gnt1;
  assign rd0    = gnt0 && !p0_we;
  assign rd1    = gnt1 && !p1_we;

  always_comb begin
    m_daddr  = '0;
    m_dwdata = '0;
    m_dwe    = '0;
    sel_oor  = 1'b0;
    if (gnt0) begin
      m_daddr  = p0_addr;
      m_dwdata = p0_wdata;
      m_dwe    = p0_we ? p0_be : 4'b0000;
      sel_oor  = oor0;
    end else if (gnt1) begin
      m_daddr  = p1_addr;
      m_dwdata = p1_wdata;
      m_dwe    = p1_we ? p1_be : 4'b0000;
      sel_oor  = oor1;
    end
    if (sel_oor) begin
      m_dwe = 4'b0000;
    end
  end

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (!p1_req || gnt1) begin
      hold_cnt_d = '0;
    end else if (gnt0) begin
      hold_cnt_d = hold_cnt_q + 4'd1;
    end
  end

  always_comb begin
    last_owner_d = OWNER_NONE;
    if (gnt0) begin
      last_owner_d = OWNER_P0;
    end else if (gnt1) begin
      last_owner_d = OWNER_P1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q   <= '0;
      last_owner_q <= OWNER_NONE;
      p0_rvalid_q  <= 1'b0;
      p1_rvalid_q  <= 1'b0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
    end else begin
      hold_cnt_q   <= hold_cnt_d;
      last_owner_q <= last_owner_d;
      p0_rvalid_q  <= rd0;
      p1_rvalid_q  <= rd1;
      if (rd0) begin
        p0_rdata_q <= oor0 ? 32'h0 : m_drdata;
      end
      if (rd1) begin
        p1_rdata_q <= oor1 ? 32'h0 : m_drdata;
      end
    end
  end

  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;

`ifdef DMEM_ARB_RANGE_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (gnt0 && oor0) || (gnt1 && oor1);
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  a_one_grant : assert property (@(posedge clk) !(gnt0 && gnt1));
  a_owner_legal : assert property (@(posedge clk) disable iff (!rst_n) last_owner_q != 2'd3);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (shadow memory, p0-streak counter, expected read returns).
module tb_dmem_arbiter;

  localparam int unsigned MAX_HOLD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [3:0]  p0_be, p1_be;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] m_daddr, m_dwdata, m_drdata;
  logic [3:0]  m_dwe;
  logic        err;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(p1_be),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .m_daddr(m_daddr), .m_dwdata(m_dwdata), .m_dwe(m_dwe), .m_drdata(m_drdata), .err(err)
  );

  // Memory behind the arbiter: combinational read, byte-lane write on posedge.
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic        init_en = 1'b0;
  logic        pre_en = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign m_drdata = mem[m_daddr[9:2]];

  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (pre_en) begin
      mem[pre_idx] <= pre_val;
    end else begin
      for (int b = 0; b < 4; b++)
        if (m_dwe[b]) mem[m_daddr[9:2]][8*b +: 8] <= m_dwdata[8*b +: 8];
    end
  end

  task automatic drive_idle();
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0; p0_be = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0; p1_be = 0;
  endtask

  task automatic init_mems();
    @(posedge clk); #1;
    init_en = 1'b1;
    @(posedge clk); #1;
    init_en = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    @(posedge clk); #1;
    pre_en = 1'b1; pre_idx = idx; pre_val = val;
    ref_mem[idx] = val;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic apply_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    p0_req = 1; p0_we = 1; p0_addr = 32'h40; p0_wdata = 32'hFFFF_FFFF; p0_be = 4'hF;
    p1_req = 1; p1_we = 1; p1_addr = 32'h44; p1_be = 4'hF;
    @(posedge clk); #1;
    tests_run++;
    if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_gnt: got p0=%b p1=%b, want 0 0", p0_gnt, p1_gnt);
    end
    tests_run++;
    if (m_dwe !== 4'b0 || m_daddr !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_bus: got dwe=%b addr=%h, want 0 0", m_dwe, m_daddr);
    end
    tests_run++;
    if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0 || p0_rdata !== 32'h0 || p1_rdata !== 32'h0
        || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_regs: got rv=%b%b rd0=%h rd1=%h err=%b, want all 0",
               p0_rvalid, p1_rvalid, p0_rdata, p1_rdata, err);
    end
    apply_reset();
  endtask

  task automatic test_read();
    preload(8'd4, 32'hDEAD_BEEF);
    p0_req = 1; p0_we = 0; p0_addr = 32'h10; p0_be = 4'hF;
    @(negedge clk);
    tests_run++;
    if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0 || m_daddr !== 32'h10 || m_dwe !== 4'b0) begin
      tests_failed++;
      $display("FAIL read_grant: got g=%b%b addr=%h dwe=%b, want g=10 addr=10 dwe=0",
               p0_gnt, p1_gnt, m_daddr, m_dwe);
    end
    @(posedge clk); #1;
    drive_idle();
    tests_run++;
    if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hDEAD_BEEF || p1_rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_data: got rv0=%b rd0=%h rv1=%b, want 1 deadbeef 0",
               p0_rvalid, p0_rdata, p1_rvalid);
    end
    @(posedge clk); #1;
    tests_run++;
    if (p0_rvalid !== 1'b0 || p0_rdata !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL read_hold: got rv0=%b rd0=%h, want 0 deadbeef", p0_rvalid, p0_rdata);
    end
  endtask

  task automatic test_write();
    preload(8'd8, 32'hAAAA_AAAA);
    p1_req = 1; p1_we = 1; p1_addr = 32'h20; p1_be = 4'b0101; p1_wdata = 32'h1122_3344;
    @(negedge clk);
    tests_run++;
    if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0 || m_dwe !== 4'b0101 || m_dwdata !== 32'h1122_3344)
    begin
      tests_failed++;
      $display("FAIL write_grant: got g=%b%b dwe=%b wd=%h, want g=01 dwe=0101 wd=11223344",
               p0_gnt, p1_gnt, m_dwe, m_dwdata);
    end
    @(posedge clk); #1;
    drive_idle();
    ref_mem[8] = 32'hAA22_AA44;
    tests_run++;
    if (mem[8] !== 32'hAA22_AA44 || p1_rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_mem: got mem=%h rv1=%b, want aa22aa44 0", mem[8], p1_rvalid);
    end
  endtask

  task automatic test_idle();
    drive_idle();
    p0_we = 1; p0_addr = 32'h1234; p0_be = 4'hF; p0_wdata = 32'h5555_5555;
    p1_we = 1; p1_addr = 32'h4321; p1_be = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0 || m_daddr !== 32'h0 || m_dwe !== 4'b0
          || m_dwdata !== 32'h0) begin
        tests_failed++;
        $display("FAIL idle_%0d: got g=%b%b addr=%h dwe=%b wd=%h, want all 0",
                 i, p0_gnt, p1_gnt, m_daddr, m_dwe, m_dwdata);
      end
      @(posedge clk); #1;
    end
    drive_idle();
  endtask

  task automatic test_fairness();
    p0_req = 1; p0_we = 0; p0_addr = 32'h10; p0_be = 4'hF;
    p1_req = 1; p1_we = 0; p1_addr = 32'h20; p1_be = 4'hF;
    for (int i = 0; i < 12; i++) begin
      logic want1;
      want1 = (i % (MAX_HOLD + 1)) == MAX_HOLD;
      @(negedge clk);
      tests_run++;
      if (p0_gnt !== !want1 || p1_gnt !== want1) begin
        tests_failed++;
        $display("FAIL fair_cycle%0d: got g=%b%b, want p1=%b", i, p0_gnt, p1_gnt, want1);
      end
      @(posedge clk); #1;
    end
    drive_idle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    p0_req = 1; p0_we = 0; p0_addr = 32'h10; p0_be = 4'hF;
    p1_req = 1; p1_we = 0; p1_addr = 32'h20; p1_be = 4'hF;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    p0_we = 1;
    #1;
    tests_run++;
    if (p0_rvalid !== 1'b0 || p0_rdata !== 32'h0 || p0_gnt !== 1'b0 || p1_gnt !== 1'b0
        || m_dwe !== 4'b0) begin
      tests_failed++;
      $display("FAIL midreset: got rv0=%b rd0=%h g=%b%b dwe=%b, want all 0",
               p0_rvalid, p0_rdata, p0_gnt, p1_gnt, m_dwe);
    end
    @(posedge clk); #1;
    tests_run++;
    if (p0_rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_rvalid: got %b, want 0", p0_rvalid);
    end
    rst_n = 1'b1;
    p0_we = 0;
    for (int i = 0; i < 5; i++) begin
      logic want1;
      want1 = (i == MAX_HOLD);
      @(negedge clk);
      tests_run++;
      if (p0_gnt !== !want1 || p1_gnt !== want1) begin
        tests_failed++;
        $display("FAIL post_reset_cycle%0d: got g=%b%b, want p1=%b", i, p0_gnt, p1_gnt, want1);
      end
      @(posedge clk); #1;
    end
    drive_idle();
    @(posedge clk); #1;
  endtask

`ifdef DMEM_ARB_RANGE_EN
  task automatic test_range();
    logic [31:0] before;
    before = mem[0];
    p1_req = 1; p1_we = 1; p1_addr = 32'h0001_0000; p1_be = 4'hF; p1_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    tests_run++;
    if (p1_gnt !== 1'b1 || m_dwe !== 4'b0) begin
      tests_failed++;
      $display("FAIL range_bus: got g1=%b dwe=%b, want 1 0", p1_gnt, m_dwe);
    end
    @(posedge clk); #1;
    drive_idle();
    tests_run++;
    if (err !== 1'b1 || mem[0] !== before) begin
      tests_failed++;
      $display("FAIL range_err: got err=%b mem0=%h, want 1 %h", err, mem[0], before);
    end
    @(posedge clk); #1;
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("FAIL range_err_pulse: got err=%b, want 0", err);
    end
  endtask
`endif

  // Model: p1 may be passed over by at most MAX_HOLD p0 grants in a row.
  task automatic test_random(input int cycles);
    int          streak = 0;
    int          who;
    logic        erv0 = 0, erv1 = 0, done0 = 0, done1 = 0;
    logic [31:0] erd0 = 0, erd1 = 0, ea, ewd, word;
    logic [3:0]  edwe;
    logic        ewe;
    init_mems();
    apply_reset();
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (done0) p0_req = 0;
      if (done1) p1_req = 0;
      if (!p0_req && $urandom_range(0, 99) < 70) begin
        p0_req = 1; p0_we = 1'($urandom_range(0, 1)); p0_addr = {22'b0, 8'($urandom), 2'b00};
        p0_wdata = $urandom; p0_be = 4'($urandom);
      end
      if (!p1_req && $urandom_range(0, 99) < 50) begin
        p1_req = 1; p1_we = 1'($urandom_range(0, 1)); p1_addr = {22'b0, 8'($urandom), 2'b00};
        p1_wdata = $urandom; p1_be = 4'($urandom);
      end
      @(negedge clk);
      tests_run++;
      if (p0_rvalid !== erv0 || p0_rdata !== erd0 || p1_rvalid !== erv1 || p1_rdata !== erd1)
      begin
        tests_failed++;
        $display("FAIL rand_read c%0d: got %b/%h %b/%h, want %b/%h %b/%h", c, p0_rvalid,
                 p0_rdata, p1_rvalid, p1_rdata, erv0, erd0, erv1, erd1);
      end
      who = 0;
      if (p0_req && !(p1_req && streak == MAX_HOLD)) who = 1;
      else if (p1_req) who = 2;
      ea = 0; ewd = 0; ewe = 0; edwe = 0;
      if (who == 1) begin ea = p0_addr; ewd = p0_wdata; ewe = p0_we; edwe = p0_we ? p0_be : 0; end
      if (who == 2) begin ea = p1_addr; ewd = p1_wdata; ewe = p1_we; edwe = p1_we ? p1_be : 0; end
      tests_run++;
      if (p0_gnt !== (who == 1) || p1_gnt !== (who == 2) || m_daddr !== ea || m_dwdata !== ewd
          || m_dwe !== edwe || err !== 1'b0) begin
        tests_failed++;
        $display("FAIL rand_bus c%0d: got g=%b%b a=%h wd=%h we=%b err=%b, want g=%0d a=%h wd=%h we=%b",
                 c, p0_gnt, p1_gnt, m_daddr, m_dwdata, m_dwe, err, who, ea, ewd, edwe);
      end
      if (!p1_req || who == 2) streak = 0;
      else if (who == 1) streak++;
      word = ref_mem[ea[9:2]];
      erv0 = (who == 1) && !ewe;
      erv1 = (who == 2) && !ewe;
      if (erv0) erd0 = word;
      if (erv1) erd1 = word;
      for (int b = 0; b < 4; b++)
        if (edwe[b]) word[8*b +: 8] = ewd[8*b +: 8];
      ref_mem[ea[9:2]] = word;
      done0 = (who == 1);
      done1 = (who == 2);
    end
    @(posedge clk); #1;
    drive_idle();
    tests_run++;
    if (p0_rvalid !== erv0 || p0_rdata !== erd0 || p1_rvalid !== erv1 || p1_rdata !== erd1) begin
      tests_failed++;
      $display("FAIL rand_tail: got %b/%h %b/%h, want %b/%h %b/%h", p0_rvalid, p0_rdata,
               p1_rvalid, p1_rdata, erv0, erd0, erv1, erd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    rst_n = 1'b0;
    test_reset();
    init_mems();
    test_read();
    test_write();
    test_idle();
    test_fairness();
    test_reset_mid();
`ifdef DMEM_ARB_RANGE_EN
    test_range();
`endif
    test_random(600);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 4, maximum consecutive port-0 grants while port 1 waits (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-003 SHALL have port rst_n, input, 1, reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have p0_req / p1_req, input, 1 each, access request from CPU (p0) and loader/debug (p1).
REQ-005 SHALL have p0_we / p1_we, input, 1 each, 1 = write, 0 = read.
REQ-006 SHALL have p0_addr / p1_addr, input, 32 each, byte address; word index = addr[31:2].
REQ-007 SHALL have p0_wdata / p1_wdata, input, 32 each, write data.
REQ-008 SHALL have p0_be / p1_be, input, 4 each, byte enables; bit n = byte lane n.
REQ-009 SHALL have p0_gnt / p1_gnt, output, 1 each, combinational; access accepted this cycle.
REQ-010 SHALL have p0_rvalid / p1_rvalid, output, 1 each, registered; read data valid.
REQ-011 SHALL have p0_rdata / p1_rdata, output, 32 each, registered read data.
REQ-012 SHALL have m_daddr, output, 32, address to memory; m_dwdata, output, 32; m_dwe, output, 4, byte write enables.
REQ-013 SHALL have m_drdata, input, 32, combinational read data from memory.
REQ-014 SHALL have err, output, 1, registered out-of-range flag (only when DMEM_ARB_RANGE_EN defined; tied 0 otherwise).

Function
REQ-015 SHALL grant at most one port per cycle; a requester SHALL hold req, we, addr, wdata, be stable until its gnt is seen.
REQ-016 SHALL grant port 0 when p0_req=1, unless the forced-fair condition (REQ-018) holds.
REQ-017 SHALL grant port 1 when p1_req=1 and p0_req=0.
REQ-018 SHALL keep 4-bit hold_cnt: increment on each p0 grant while p1_req=1; clear on any p1 grant or when p1_req=0; when hold_cnt==MAX_HOLD and p1_req=1, grant port 1 regardless of p0_req.
REQ-019 SHALL drive m_daddr, m_dwdata from the granted port; m_dwe = be of granted port when its we=1, else 4'b0000.
REQ-020 SHALL drive m_daddr=0, m_dwdata=0, m_dwe=0 when no grant.
REQ-021 SHALL, on a granted read, register m_drdata into px_rdata and assert px_rvalid for exactly the next cycle (latency 1).
REQ-022 SHALL keep px_rdata unchanged when px_rvalid=0; px_rvalid SHALL not assert for writes.
REQ-023 SHALL complete a granted write at the same rising edge as the grant (memory writes on posedge).
REQ-024 SHALL allow back-to-back grants to the same port every cycle (throughput 1 access/cycle).
REQ-025 SHALL track state last_owner in {NONE, P0, P1}: NONE after reset or idle cycle, else the port granted last cycle.

Reset
REQ-026 SHALL, while rst_n=0, clear hold_cnt, last_owner=NONE, p0/p1_rvalid=0, p0/p1_rdata=0, err=0; gnt and m_dwe SHALL be 0 (no memory write during reset).
REQ-027 SHALL, on reset asserted mid-access, discard any pending rvalid; first grant possible in the first cycle after rst_n rises.

Configuration
REQ-028 SHALL, with DMEM_ARB_RANGE_EN defined, treat an access with addr[31:14] != 0 as out-of-range: still grant it, force m_dwe=0, return rdata=0 with rvalid for reads, pulse err for one cycle after the grant.
REQ-029 SHALL, without DMEM_ARB_RANGE_EN, perform no range check and tie err to 0.

Verification
REQ-030 p0 read addr 0x10 with word 0xDEADBEEF at index 4 -> p0_gnt same cycle, p0_rvalid=1 and p0_rdata=0xDEADBEEF next cycle.
REQ-031 p1 write addr 0x20, be=4'b0101, wdata=0x11223344 over 0xAAAAAAAA -> memory word index 8 reads 0xAA22AA44.
REQ-032 p0_req and p1_req held high 12 cycles, MAX_HOLD=4 -> grant pattern P0,P0,P0,P0,P1 repeating; p1 never waits >4 cycles.
REQ-033 rst_n pulled low the cycle after a p0 read grant -> p0_rvalid stays 0, m_dwe=0, hold_cnt=0 after release.
REQ-034 DMEM_ARB_RANGE_EN defined, p1 write addr 0x0001_0000 -> m_dwe=0, err=1 for one cycle; memory unchanged.
REQ-035 no requests for 3 cycles -> m_daddr=0, m_dwe=0, both gnt=0, last_owner=NONE.
